// File: rtl/serial_rx_os.sv
// 16x-oversampling asynchronous serial receiver with majority-vote bit sampling,
// configurable parity/stop bits and a single-entry valid/ready output holding register.
module serial_rx_os #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 2,
  parameter int STOP_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV    = CLK_FREQ / (16 * BAUD);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e state_q, state_d;

  logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [1:0]           settle_q, settle_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [3:0]           tick_idx_q, tick_idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic tick, mid_bit, end_bit, maj, fall_edge, parity_bad, complete, ferr_final;

  // The edge detector stays disarmed until the synchronizer has flushed its
  // reset value, so a line already low after reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      settle_q   <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      settle_q   <= settle_d;
    end
  end

  assign settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
  assign fall_edge = (settle_q == 2'd3) && rxd_prev_q && !rxd_sync_q;

  assign tick    = (state_q != S_IDLE) && (div_cnt_q == DIV_MAX);
  assign mid_bit = tick && (tick_idx_q == 4'd9);
  assign end_bit = tick && (tick_idx_q == 4'd15);
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_sync_q) | (samp_q[1] & rxd_sync_q);

  always_comb begin
    parity_bad = 1'b0;
    case (PARITY)
      1:       parity_bad = (^shift_q) ^ maj;
      2:       parity_bad = ~((^shift_q) ^ maj);
      3:       parity_bad = ~maj;
      4:       parity_bad = maj;
      default: parity_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_d    = state_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    tick_idx_d = tick ? tick_idx_q + 4'd1 : tick_idx_q;
    samp_d     = samp_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    complete   = 1'b0;

    if (tick && tick_idx_q == 4'd7) samp_d[0] = rxd_sync_q;
    if (tick && tick_idx_q == 4'd8) samp_d[1] = rxd_sync_q;

    case (state_q)
      S_IDLE: begin
        div_cnt_d  = '0;
        tick_idx_d = 4'd0;
        if (fall_edge) begin
          state_d    = S_START;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      S_START: begin
        if (mid_bit && maj)  state_d = S_IDLE;
        else if (end_bit)    state_d = S_DATA;
      end
      S_DATA: begin
        if (mid_bit) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (end_bit) begin
          if (bit_cnt_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (mid_bit) perr_d = parity_bad;
        if (end_bit) state_d = S_STOP;
      end
      S_STOP: begin
        if (mid_bit) begin
          if (!maj) ferr_d = 1'b1;
          // The last stop bit ends the frame at mid-bit to leave room for the next start edge.
          if (stop_cnt_q == LAST_STOP) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (end_bit) begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ferr_final = ferr_q | ~maj;

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    if (complete && (!rx_valid_q || rx_ready)) begin
      rx_data_d    = shift_q;
      rx_valid_d   = 1'b1;
      parity_err_d = perr_q;
      frame_err_d  = ferr_final;
      if (rx_valid_q) overrun_d = 1'b0;
    end else if (complete) begin
      overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      tick_idx_q   <= 4'd0;
      samp_q       <= 2'b00;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      tick_idx_q   <= tick_idx_d;
      samp_q       <= samp_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_rx_os.sv
// Scoreboard bench for serial_rx_os at 8O2, 160 clocks per bit: directed frames,
// glitch, overrun and mid-frame reset cases, then randomized frames.
module tb_serial_rx_os;

  localparam int CLK_FREQ = 1536000;
  localparam int BAUD     = 9600;
  localparam int BIT_CLK  = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, busy;

  always #5 clk = ~clk;

  serial_rx_os #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DATA_BITS(8),
    .PARITY   (2),
    .STOP_BITS(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  bit   model_held = 1'b0;
  bit   model_ovr  = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
  endtask

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_pbit(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                            input logic s2, input int gap);
    exp_t e;
    e.data      = d;
    e.perr      = (($countones(d) + int'(pbit)) % 2) != 1;
    e.ferr      = !(s1 && s2);
    e.start_cyc = cyc;
    if (rx_ready || !model_held) begin
      exp_q.push_back(e);
      model_held = !rx_ready;
    end else begin
      model_ovr = 1'b1;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(pbit);
    drive_bit(s1);
    drive_bit(s2);
    rxd = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  // Monitor: compares on each rising rx_valid and pops on each accepted handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid && !prev_valid) begin
        check("rise_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("rx_data", rx_data, exp_q[0].data);
          check("parity_err", parity_err, exp_q[0].perr);
          check("frame_err", frame_err, exp_q[0].ferr);
          check_range("latency_clk", cyc - exp_q[0].start_cyc, 1855, 1870);
        end
      end
      if (rx_valid && rx_ready) begin
        check("accept_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("rx_data_at_accept", rx_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
      prev_valid = rx_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       pb, s1, s2;

    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    send_frame(8'h55, 1'b1, 1'b1, 1'b1, 40);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 40);
    send_frame(8'h0F, 1'b1, 1'b1, 1'b0, 40);

    rxd = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_busy_high", busy, 1);
    repeat (10) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (110) @(posedge clk);
    #1;
    check("glitch_busy_low", busy, 0);
    check("glitch_no_valid", rx_valid, 0);

    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, 1'b1, 40);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1, 40);
    check("held_rx_valid", rx_valid, 1);
    check("held_rx_data", rx_data, 8'h11);
    check("held_overrun", overrun, model_ovr);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready   = 1'b0;
    model_held = 1'b0;
    model_ovr  = 1'b0;
    @(negedge clk);
    check("after_accept_rx_valid", rx_valid, 0);
    check("after_accept_overrun", overrun, model_ovr);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;

    rxd = 1'b0;
    repeat (BIT_CLK + BIT_CLK / 2) @(posedge clk);
    #1;
    check("midframe_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rx_data", rx_data, 0);
    check("async_rst_rx_valid", rx_valid, 0);
    check("async_rst_parity_err", parity_err, 0);
    check("async_rst_frame_err", frame_err, 0);
    check("async_rst_overrun", overrun, 0);
    check("async_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("held_low_no_start", busy, 0);
    check("held_low_no_valid", rx_valid, 0);
    rxd = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 40);

    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom);
      pb = odd_pbit(d) ^ ($urandom_range(0, 3) == 0);
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      send_frame(d, pb, s1, s2, $urandom_range(20, 300));
    end

    repeat (200) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
